// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle between the sync generator and the pixel colour stage.
// The generator drives the raster signals; pix_en comes from the pixel-rate enable source.
interface vga_sync_gen_if;
  logic       pix_en;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       visible;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    input  pix_en,
    output hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
  );

  modport slave (
    input pix_en, hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel/line counters with registered sync, visible and strobes.
// Every output is a flop computed from the next counter values, so all describe one pixel.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  vga_sync_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEGIN = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEGIN = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [9:0] r_hpos;
  logic [9:0] r_vpos;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_visible;
  logic       r_line_start;
  logic       r_frame_start;
  logic [7:0] r_frame_count;

  logic       w_h_last;
  logic       w_v_last;
  logic [9:0] w_hpos_d;
  logic [9:0] w_vpos_d;
  logic       w_hs_act;
  logic       w_vs_act;
  logic       w_visible_d;

  // Using >= lets any out-of-range count fall back to 0 on the next enabled edge.
  always_comb begin
    w_h_last = (r_hpos >= H_LAST);
    w_v_last = (r_vpos >= V_LAST);
    w_hpos_d = w_h_last ? 10'd0 : r_hpos + 10'd1;
    w_vpos_d = r_vpos;
    if (w_h_last) begin
      w_vpos_d = w_v_last ? 10'd0 : r_vpos + 10'd1;
    end
    w_hs_act    = (w_hpos_d >= HS_BEGIN) && (w_hpos_d <= HS_END);
    w_vs_act    = (w_vpos_d >= VS_BEGIN) && (w_vpos_d <= VS_END);
    w_visible_d = (w_hpos_d < H_VIS) && (w_vpos_d < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hpos        <= 10'd0;
      r_vpos        <= 10'd0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_visible     <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'd0;
    end else if (bus.pix_en) begin
      r_hpos        <= w_hpos_d;
      r_vpos        <= w_vpos_d;
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_visible     <= w_visible_d;
      r_line_start  <= w_h_last;
      r_frame_start <= w_h_last && w_v_last;
      if (w_h_last && w_v_last) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign bus.hpos        = r_hpos;
  assign bus.vpos        = r_vpos;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.visible     = r_visible;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a small raster in both sync polarities, checked every cycle
// against a model that derives position from the count of enabled edges since reset.
module tb_vga_sync_gen;

  localparam int HD = 10;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 4;
  localparam int VD = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk;
  logic rst_n;
  logic pix_en;

  vga_sync_gen_if u_if0 ();
  vga_sync_gen_if u_if1 ();

  assign u_if0.pix_en = pix_en;
  assign u_if1.pix_en = pix_en;

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0)
  ) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if0)
  );

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b1)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: enabled edges since reset, and whether the last edge was enabled.
  int n_edges  = 0;
  bit m_strobe = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model_vec(input bit pol);
    int  hp, vp, fc;
    bit  hs_act, vs_act, vis, ls, fs;
    hp     = n_edges % HT;
    vp     = (n_edges / HT) % VT;
    fc     = (n_edges / FT) % 256;
    hs_act = (hp >= HD + HF) && (hp < HD + HF + HS);
    vs_act = (vp >= VD + VF) && (vp < VD + VF + VS);
    vis    = (hp < HD) && (vp < VD);
    ls     = m_strobe && (hp == 0);
    fs     = ls && (vp == 0);
    return {10'(hp), 10'(vp), hs_act ~^ pol, vs_act ~^ pol, vis, ls, fs, 8'(fc)};
  endfunction

  task automatic check_all();
    chk("pol0_vec", {u_if0.hpos, u_if0.vpos, u_if0.hsync, u_if0.vsync, u_if0.visible,
                     u_if0.line_start, u_if0.frame_start, u_if0.frame_count}, model_vec(1'b0));
    chk("pol1_vec", {u_if1.hpos, u_if1.vpos, u_if1.hsync, u_if1.vsync, u_if1.visible,
                     u_if1.line_start, u_if1.frame_start, u_if1.frame_count}, model_vec(1'b1));
  endtask

  task automatic step(input logic en, input logic rst_in);
    rst_n  = rst_in;
    pix_en = en;
    @(posedge clk);
    if (!rst_in) begin
      n_edges  = 0;
      m_strobe = 1'b0;
    end else if (en) begin
      n_edges++;
      m_strobe = 1'b1;
    end else begin
      m_strobe = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_hpos"}, 64'(u_if0.hpos), 64'd0);
    chk({tag, "_vpos"}, 64'(u_if0.vpos), 64'd0);
    chk({tag, "_vis"}, 64'(u_if0.visible), 64'd1);
    chk({tag, "_sync0"}, 64'({u_if0.hsync, u_if0.vsync}), 64'h3);
    chk({tag, "_sync1"}, 64'({u_if1.hsync, u_if1.vsync}), 64'h0);
    chk({tag, "_strb"}, 64'({u_if0.line_start, u_if0.frame_start}), 64'h0);
    chk({tag, "_fc"}, 64'(u_if0.frame_count), 64'd0);
  endtask

  int hs_cnt, vs_cnt, vs1_cnt, ls_cnt, fs_cnt, fs_seen;

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check_reset_values("rst");

    // First line: hsync width and a single line_start at the wrap.
    hs_cnt = 0;
    ls_cnt = 0;
    for (int i = 0; i < HT; i++) begin
      step(1'b1, 1'b1);
      if (!u_if0.hsync) hs_cnt++;
      if (u_if0.line_start) ls_cnt++;
    end
    chk("line_hsync_cnt", 64'(hs_cnt), 64'(HS));
    chk("line_ls_cnt", 64'(ls_cnt), 64'd1);
    chk("line_wrap_vpos", 64'(u_if0.vpos), 64'd1);

    // Rest of the first frame: vsync width and exactly one frame_start at its end.
    vs_cnt  = 0;
    vs1_cnt = 0;
    fs_cnt  = 0;
    for (int i = HT; i < FT; i++) begin
      step(1'b1, 1'b1);
      if (!u_if0.vsync) vs_cnt++;
      if (u_if1.vsync) vs1_cnt++;
      if (u_if0.frame_start) fs_cnt++;
    end
    chk("frame_vsync_cnt", 64'(vs_cnt), 64'(VS * HT));
    chk("frame_vsync1_cnt", 64'(vs1_cnt), 64'(VS * HT));
    chk("frame_fs_cnt", 64'(fs_cnt), 64'd1);
    chk("frame_fc", 64'(u_if0.frame_count), 64'd1);

    // Half rate: counters move on every other clock only.
    for (int i = 0; i < 2 * HT + 6; i++) step(1'(i % 2 == 0), 1'b1);

    // Random enable pattern.
    for (int i = 0; i < 1500; i++) step(1'($urandom_range(0, 2) != 0), 1'b1);

    // Mid-frame reset at a chosen raster position.
    step(1'b1, 1'b0);
    for (int i = 0; i < 7 * HT + 15; i++) step(1'b1, 1'b1);
    chk("pre_rst_pos", 64'({u_if0.vpos, u_if0.hpos}), 64'({10'd7, 10'd15}));
    step(1'b1, 1'b0);
    check_reset_values("midrst");
    step(1'b0, 1'b1);
    chk("post_rst_hold", 64'(u_if0.hpos), 64'd0);
    step(1'b1, 1'b1);
    chk("post_rst_hpos", 64'(u_if0.hpos), 64'd1);

    // 256 frames from reset: frame_count wraps 255 -> 0 on the 256th frame_start.
    step(1'b1, 1'b0);
    fs_seen = 0;
    for (int i = 0; i < 257 * FT && fs_seen < 256; i++) begin
      step(1'b1, 1'b1);
      if (u_if0.frame_start) begin
        fs_seen++;
        if (fs_seen == 255) chk("fc_255", 64'(u_if0.frame_count), 64'd255);
        if (fs_seen == 256) chk("fc_wrap", 64'(u_if0.frame_count), 64'd0);
      end
    end
    chk("wrap_fs_seen", 64'(fs_seen), 64'd256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator that sits directly upstream of the pixel colour stage.
- Produces the hpos, vpos, hsync, vsync and visible signals that the colour stage consumes, plus line/frame strobes and a free-running frame counter.
- Default timing is 640x480 at 60 Hz (800x525 total) with a pixel-rate clock enable, so the block runs from a faster system clock.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync polarity (0 = active-low pulses, 1 = active-high pulses)

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- pix_en  input  1  pixel clock enable; counters advance only when high
- hpos  output  10  current pixel column, 0..H_TOTAL-1
- vpos  output  10  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity per SYNC_POL
- vsync  output  1  vertical sync, polarity per SYNC_POL
- visible  output  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- line_start  output  1  one-cycle pulse when hpos becomes 0
- frame_start  output  1  one-cycle pulse when (hpos,vpos) becomes (0,0)
- frame_count  output  8  count of completed frames, wraps at 255->0

Behaviour:
- Reset is rst_n, synchronous, active-low; clock is clk.
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 by default).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525 by default).
- Reset values:
  - hpos=0, vpos=0, visible=1, hsync and vsync inactive (=~SYNC_POL).
  - line_start=0, frame_start=0, frame_count=0.
- All outputs are flops. On every cycle, hpos, vpos, hsync, vsync and visible describe the same pixel. Sync and visible are computed from the next-state counter values, so they have zero skew relative to hpos/vpos.
- On a clk edge with pix_en=1:
  - hpos increments.
  - When hpos==H_TOTAL-1, hpos wraps to 0 and vpos increments.
  - When vpos==V_TOTAL-1 on that same wrap, vpos wraps to 0 and frame_count increments (mod 256).
- With pix_en=0, all counters and levels hold, and line_start/frame_start are 0.
- hsync is active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]; by default this is 656..751.
- vsync is active for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1]; by default this is 490..491, spanning whole lines and changing only at hpos==0.
- line_start is 1 for exactly the one clk cycle in which the registered hpos first equals 0 after a wrap. frame_start behaves the same way when both counters first equal 0 after a wrap; it coincides with line_start.
- Neither strobe fires out of reset; the first frame_start comes after one full frame.
- Reset mid-frame: on the next edge, all outputs return to their reset values regardless of pix_en. Reset has priority over pix_en.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1; any out-of-range value forces a wrap to 0 on the next enabled edge.
- Downstream colour logic samples vsync rising/falling edges and vpos==0. The timing above guarantees that vpos==0 persists for H_TOTAL enabled cycles per frame.

Test Plan:
- Reset with pix_en=1 held high -> hpos=0, vpos=0, visible=1, hsync=vsync=1 (SYNC_POL=0), frame_count=0; no strobes during the first frame.
- Run one line -> visible falls at hpos=640; hsync=0 for hpos 656..751 (96 enabled cycles); hpos wraps 799->0 with vpos 0->1 and line_start=1 for 1 cycle.
- Run one full frame -> vsync=0 for vpos 490..491 (1600 enabled cycles); at (799,524)->(0,0), frame_start=1, line_start=1 and frame_count 0->1. Total of 420000 enabled cycles per frame.
- pix_en toggled 1,0,1,0 (half rate) -> hpos advances once per two clk cycles; outputs hold on disabled cycles; strobes stay 1 clk wide and only appear on enabled edges.
- Assert rst_n=0 for 1 cycle at hpos=700, vpos=300 -> next cycle all outputs equal reset values; counting restarts from (0,0) with frame_count=0.
- Run 256 frames -> frame_count wraps 255->0 on the 256th frame_start; SYNC_POL=1 build -> hsync/vsync pulses inverted, same positions.
